// File: rtl/drive_cmd_pkg.sv
// Drive command codes shared by the UART command receiver and the PWM stage,
// plus the receiver's bit-level state type.
package drive_cmd_pkg;

  localparam logic [7:0] ACT_IDLE  = 8'h30;
  localparam logic [7:0] ACT_FWD   = 8'h31;
  localparam logic [7:0] ACT_REV   = 8'h32;
  localparam logic [7:0] ACT_LEFT  = 8'h33;
  localparam logic [7:0] ACT_RIGHT = 8'h34;
  localparam logic [7:0] ACT_MIN   = ACT_IDLE;
  localparam logic [7:0] ACT_MAX   = ACT_RIGHT;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } rx_state_e;

  function automatic logic is_drive_cmd(input logic [7:0] code);
    return (code >= ACT_MIN) && (code <= ACT_MAX);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: rx synchronizer, bit-timing FSM and stop-bit framing.
// byte_ok / frame_err are strobes in the stop-bit sample cycle.
module uart_rx_core
  import drive_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       frame_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

  logic            rx_meta;
  logic            rxs;
  rx_state_e       state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            stop_sample;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= StIdle;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (!rxs) state <= StStart;
        end
        StStart: begin
          if (cnt == CntHalf) begin
            // Still low at mid start bit: real frame, otherwise a glitch.
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rxs ? StIdle : StData;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StData: begin
          if (cnt == CntLast) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == 3'd7) state <= StStop;
            else bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StStop: begin
          // Leave at the stop-bit centre to absorb baud mismatch.
          if (cnt == CntLast) begin
            cnt   <= '0;
            state <= rxs ? StIdle : StWaitHigh;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StWaitHigh: begin
          if (rxs) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    stop_sample = (state == StStop) && (cnt == CntLast);
    byte_ok     = stop_sample && rxs;
    frame_err   = stop_sample && !rxs;
    rx_byte     = shift;
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Drive command receiver: decodes UART bytes into a held action code and
// forces IDLE when the link goes quiet for TIMEOUT_CYCLES.
module uart_cmd_rx
  import drive_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 5208,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] action,
  output logic       cmd_valid,
  output logic       cmd_reject,
  output logic       frame_err,
  output logic       link_timeout
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WdW-1:0] WdMax  = WdW'(TIMEOUT_CYCLES);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [7:0]     rx_byte;
  logic           byte_ok;
  logic           core_frame_err;
  logic           valid_now;
  logic           reject_now;
  logic           expire;
  logic [WdW-1:0] wd_cnt;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_byte  (rx_byte),
    .byte_ok  (byte_ok),
    .frame_err(core_frame_err)
  );

  always_comb begin
    valid_now  = byte_ok && is_drive_cmd(rx_byte);
    reject_now = byte_ok && !is_drive_cmd(rx_byte);
    // A command arriving in the expiry cycle takes priority.
    expire     = (wd_cnt == WdLast) && !valid_now;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      action       <= ACT_IDLE;
      cmd_valid    <= 1'b0;
      cmd_reject   <= 1'b0;
      frame_err    <= 1'b0;
      link_timeout <= 1'b0;
      wd_cnt       <= '0;
    end else begin
      cmd_valid  <= valid_now;
      cmd_reject <= reject_now;
      frame_err  <= core_frame_err;
      if (valid_now) begin
        action       <= rx_byte;
        link_timeout <= 1'b0;
        wd_cnt       <= '0;
      end else begin
        if (wd_cnt != WdMax) wd_cnt <= wd_cnt + 1'b1;
        if (expire) begin
          action       <= ACT_IDLE;
          link_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with short bit time and watchdog.
module tb_uart_cmd_rx;

  localparam int unsigned CPB = 16;
  localparam int unsigned TO  = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] action;
  logic       cmd_valid;
  logic       cmd_reject;
  logic       frame_err;
  logic       link_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_reject = 0;
  int n_ferr   = 0;
  int cyc      = 0;
  int last_valid_cyc = 0;
  int to_cyc   = 0;
  logic lt_prev = 1'b0;

  uart_cmd_rx #(
    .CLKS_PER_BIT  (CPB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .action      (action),
    .cmd_valid   (cmd_valid),
    .cmd_reject  (cmd_reject),
    .frame_err   (frame_err),
    .link_timeout(link_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (cmd_valid === 1'b1) begin
      n_valid = n_valid + 1;
      last_valid_cyc = cyc;
    end
    if (cmd_reject === 1'b1) n_reject = n_reject + 1;
    if (frame_err === 1'b1) n_ferr = n_ferr + 1;
    if (link_timeout === 1'b1 && lt_prev !== 1'b1) to_cyc = cyc;
    lt_prev = link_timeout;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    @(posedge clk);
    n_valid  = 0;
    n_reject = 0;
    n_ferr   = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
    rx = 1'b1;
    idle(6);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    idle(3);
    rst = 1'b1;
    idle(2);
    n_checks++;
    if (action !== 8'h30) begin
      n_fail++; $display("FAIL reset_action: got %h expected 30", action);
    end
    n_checks++;
    if (cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_valid: got %b expected 0", cmd_valid);
    end
    n_checks++;
    if (cmd_reject !== 1'b0) begin
      n_fail++; $display("FAIL reset_cmd_reject: got %b expected 0", cmd_reject);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
    end
    n_checks++;
    if (link_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_link_timeout: got %b expected 0", link_timeout);
    end
  endtask

  task automatic test_valid();
    clear_counts();
    send_byte(8'h31, 1'b1);
    n_checks++;
    if (n_valid !== 1) begin
      n_fail++; $display("FAIL valid_pulses: got %0d expected 1", n_valid);
    end
    n_checks++;
    if (n_reject + n_ferr !== 0) begin
      n_fail++; $display("FAIL valid_other_pulses: got %0d expected 0", n_reject + n_ferr);
    end
    idle(20);
    n_checks++;
    if (action !== 8'h31) begin
      n_fail++; $display("FAIL valid_action_held: got %h expected 31", action);
    end
  endtask

  task automatic test_reject();
    clear_counts();
    send_byte(8'h34, 1'b1);
    n_checks++;
    if (action !== 8'h34 || n_valid !== 1) begin
      n_fail++; $display("FAIL right_cmd: got action %h valid %0d expected 34 / 1", action, n_valid);
    end
    clear_counts();
    send_byte(8'h41, 1'b1);
    n_checks++;
    if (n_reject !== 1) begin
      n_fail++; $display("FAIL reject_pulses: got %0d expected 1", n_reject);
    end
    n_checks++;
    if (n_valid + n_ferr !== 0) begin
      n_fail++; $display("FAIL reject_other_pulses: got %0d expected 0", n_valid + n_ferr);
    end
    n_checks++;
    if (action !== 8'h34) begin
      n_fail++; $display("FAIL reject_action: got %h expected 34", action);
    end
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_byte(8'h32, 1'b0);
    n_checks++;
    if (n_ferr !== 1) begin
      n_fail++; $display("FAIL ferr_pulses: got %0d expected 1", n_ferr);
    end
    n_checks++;
    if (n_valid + n_reject !== 0) begin
      n_fail++; $display("FAIL ferr_other_pulses: got %0d expected 0", n_valid + n_reject);
    end
    n_checks++;
    if (action !== 8'h34) begin
      n_fail++; $display("FAIL ferr_action: got %h expected 34", action);
    end
    idle(10);
    clear_counts();
    send_byte(8'h33, 1'b1);
    n_checks++;
    if (n_valid !== 1 || action !== 8'h33) begin
      n_fail++; $display("FAIL after_ferr: got action %h valid %0d expected 33 / 1", action, n_valid);
    end
  endtask

  task automatic test_timeout();
    int waited;
    send_byte(8'h31, 1'b1);
    waited = 0;
    while (link_timeout !== 1'b1 && waited < 2300) begin
      @(negedge clk);
      waited++;
    end
    #1;
    n_checks++;
    if (link_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_reached: got %b expected 1", link_timeout);
    end
    n_checks++;
    if ((to_cyc - last_valid_cyc) < 1999 || (to_cyc - last_valid_cyc) > 2001) begin
      n_fail++; $display("FAIL timeout_latency: got %0d expected 2000", to_cyc - last_valid_cyc);
    end
    n_checks++;
    if (action !== 8'h30) begin
      n_fail++; $display("FAIL timeout_action: got %h expected 30", action);
    end
    send_byte(8'h32, 1'b1);
    n_checks++;
    if (action !== 8'h32) begin
      n_fail++; $display("FAIL recover_action: got %h expected 32", action);
    end
    n_checks++;
    if (link_timeout !== 1'b0) begin
      n_fail++; $display("FAIL recover_link_timeout: got %b expected 0", link_timeout);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(CPB * 12);
    n_checks++;
    if (n_valid + n_reject + n_ferr !== 0) begin
      n_fail++; $display("FAIL glitch_pulses: got %0d expected 0", n_valid + n_reject + n_ferr);
    end
    clear_counts();
    send_byte(8'h33, 1'b1);
    n_checks++;
    if (n_valid !== 1 || action !== 8'h33) begin
      n_fail++; $display("FAIL after_glitch: got action %h valid %0d expected 33 / 1", action, n_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    b = 8'h34;
    clear_counts();
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (action !== 8'h30) begin
      n_fail++; $display("FAIL midreset_action: got %h expected 30", action);
    end
    n_checks++;
    if (link_timeout !== 1'b0 || cmd_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flags: got lt %b valid %b expected 0 / 0", link_timeout, cmd_valid);
    end
    rx = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(CPB * 12);
    n_checks++;
    if (n_valid + n_reject + n_ferr !== 0) begin
      n_fail++; $display("FAIL midreset_pulses: got %0d expected 0", n_valid + n_reject + n_ferr);
    end
    clear_counts();
    send_byte(8'h34, 1'b1);
    n_checks++;
    if (n_valid !== 1 || action !== 8'h34) begin
      n_fail++; $display("FAIL after_midreset: got action %h valid %0d expected 34 / 1", action, n_valid);
    end
  endtask

  initial begin
    test_reset();
    test_valid();
    test_reject();
    test_frame_err();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- Upstream stage of the motor PWM block. Receives ASCII drive commands over a serial link (Bluetooth UART module) and decodes them.
- Produces the held 8-bit `action` code that the PWM stage consumes.
- Valid commands: '0' idle, '1' forward, '2' reverse, '3' turn left, '4' turn right.
- Contains a link-loss watchdog that forces IDLE when no valid command arrives for a configurable time.

Parameters:
- CLKS_PER_BIT, default 5208. Clock cycles per UART bit (50 MHz / 9600 baud); minimum 4.
- TIMEOUT_CYCLES, default 25_000_000. Cycles without a valid command before forcing IDLE (0.5 s at 50 MHz); minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- rx  in  1  serial input: idle-high, 8N1, LSB first; asynchronous to clk.
- action  out  8  held command code to the PWM stage.
- cmd_valid  out  1  one-cycle pulse: `action` was just loaded from a received byte.
- cmd_reject  out  1  one-cycle pulse: a well-framed byte outside 8'h30..8'h34 was received.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- link_timeout  out  1  level; high while the watchdog has forced IDLE.

Behaviour:
- Reset values (rst=0, immediate): action=8'h30, cmd_valid=0, cmd_reject=0, frame_err=0, link_timeout=0, FSM=IDLE, watchdog counter=0. Synchronizer flops reset to 1.
- rx input: 2-flop synchronizer. All decisions use the synchronized value `rxs`.
- Bit-timing counter: counts 0..CLKS_PER_BIT-1. Sized with $clog2.
- IDLE state:
  - On rxs==0 → START, counter cleared.
- START state:
  - At count CLKS_PER_BIT/2 (integer division), sample rxs.
  - 0 → DATA, bit index 0, counter cleared.
  - 1 → glitch; back to IDLE with no pulse.
- DATA state:
  - Each time the counter reaches CLKS_PER_BIT-1, sample rxs into shift[bit index]. This lands at the bit centre, LSB first.
  - After bit 7 → STOP.
- STOP state: at the stop-bit centre, sample rxs.
  - rxs==1 and byte in 8'h30..8'h34: on the next cycle, action=byte, cmd_valid=1, watchdog cleared, link_timeout=0. Go to IDLE.
  - rxs==1 and byte out of range: cmd_reject=1 next cycle. action is unchanged and the watchdog is not cleared. Go to IDLE.
  - rxs==0: frame_err=1 next cycle; byte discarded → WAIT_HIGH.
- WAIT_HIGH state: stay until rxs==1, then → IDLE. This covers a break condition or a held-low line.
- Latency: pulses and the action update occur exactly 1 cycle after the stop-bit sample cycle. Total from rx start-bit falling edge ≈ 2 (sync) + 9.5·CLKS_PER_BIT + 1 cycles.
- Re-sending the same code still pulses cmd_valid and clears the watchdog; action is unchanged.
- Watchdog counter:
  - Increments every cycle, saturating at TIMEOUT_CYCLES.
  - When it reaches TIMEOUT_CYCLES-1 with no valid command that cycle: action=8'h30 and link_timeout=1 the next cycle. Both hold until the next valid command.
  - Counter is not cleared by rejects, frame errors, or partial frames.
- Simultaneous events: a valid command in the same cycle as watchdog expiry → the command wins. action=byte, link_timeout stays/becomes 0, counter cleared.
- Pulse outputs are mutually exclusive; at most one per received frame.
- No buffering: one byte in flight at a time. The FSM returns to IDLE at the stop-bit centre to tolerate ±4% baud mismatch.
- Reset mid-frame: the frame is abandoned, all state returns to reset values, and no pulse is emitted.

Decomposition:
- Shared package (drive_cmd_pkg):
  - ACT_IDLE=8'h30, ACT_FWD=8'h31, ACT_REV=8'h32, ACT_LEFT=8'h33, ACT_RIGHT=8'h34, plus ACT_MIN/ACT_MAX.
  - The PWM stage imports the same constants.
- Sub-module uart_rx_core holds the synchronizer, bit FSM and framing. Outputs: byte[7:0], byte_ok pulse, frame_err pulse.
- Top holds range check, action register, watchdog and link_timeout.

Test Plan (bench uses CLKS_PER_BIT=16, TIMEOUT_CYCLES=2000):
1. Release rst, rx idle high → action=8'h30, all pulses 0, link_timeout=0. Send 8'h31 → exactly one cmd_valid pulse; action=8'h31 held afterwards.
2. Send 8'h34 then 8'h41 ('A') → action=8'h34 with cmd_valid; then one cmd_reject pulse, action stays 8'h34.
3. Send 8'h32 with the stop bit driven low, then rx high → one frame_err pulse, action unchanged. Next byte 8'h33 is decoded correctly.
4. Send 8'h31, then idle 2000 cycles → action=8'h30 and link_timeout=1 at cycle 2000 ±1. Send 8'h32 → action=8'h32, link_timeout=0.
5. Drive an rx low glitch of 5 cycles → no pulses, FSM back in IDLE. A following 8'h33 is received correctly.
6. Assert rst low during the DATA bits of 8'h34 → action=8'h30 immediately, no pulse. After release, a full 8'h34 frame → cmd_valid, action=8'h34.
